// File: rtl/gpio_sampler_pkg.sv
// Shared constants for the GPIO input sampler.
package gpio_sampler_pkg;

  localparam logic MODE_CHANGE   = 1'b0;
  localparam logic MODE_PERIODIC = 1'b1;

  localparam int unsigned TSTAMP_W = 16;
  localparam int unsigned DIV_W    = 16;

endpackage

// File: rtl/gpio_sync_fifo.sv
// Show-ahead FIFO: head entry is visible on rdata whenever not empty, zero otherwise.
// A pop on an empty FIFO is ignored; a push while full is accepted only if a pop frees a slot.
module gpio_sync_fifo #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     push,
  input  logic                     pop,
  input  logic [DATA_W-1:0]        wdata,
  output logic [DATA_W-1:0]        rdata,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned LvlW = $clog2(DEPTH) + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [LvlW-1:0]   level_q, level_d;
  logic              do_push, do_pop;

  assign empty   = (level_q == '0);
  assign full    = (level_q == LvlW'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_comb begin
    level_d = level_q;
    unique case ({do_push, do_pop})
      2'b10:   level_d = level_q + LvlW'(1);
      2'b01:   level_d = level_q - LvlW'(1);
      default: level_d = level_q;
    endcase
  end

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      level_q <= level_d;
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= wdata;
  end

  assign rdata = empty ? '0 : mem[rd_ptr_q];
  assign level = level_q;

endmodule

// File: rtl/gpio_in_sampler.sv
// GPIO pin synchroniser and sampler feeding a small show-ahead FIFO.
// Define GPIO_SAMPLER_TSTAMP_EN to store a 16-bit cycle timestamp with each sample.
module gpio_in_sampler
  import gpio_sampler_pkg::*;
#(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [WIDTH-1:0]         gpio_pins,
  input  logic                     sample_en,
  input  logic                     mode,
  input  logic [DIV_W-1:0]         div,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         dout,
  output logic                     dout_valid,
`ifdef GPIO_SAMPLER_TSTAMP_EN
  output logic [TSTAMP_W-1:0]      dout_tstamp,
`endif
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     overflow,
  input  logic                     ovf_clr
);

`ifdef GPIO_SAMPLER_TSTAMP_EN
  localparam int unsigned DataW = WIDTH + TSTAMP_W;
`else
  localparam int unsigned DataW = WIDTH;
`endif

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] sync_out, prev_q;
  logic [DIV_W-1:0] div_cnt_q;
  logic             overflow_q;
  logic             change, tick, push_req, pop, drop, empty;
  logic [DataW-1:0] wdata, rdata;

  assign sync_out = sync_q[SYNC_STAGES-1];
  assign change   = (sync_out != prev_q);
  assign tick     = (div_cnt_q == div);
  assign push_req = sample_en & ((mode == MODE_PERIODIC) ? tick : change);
  assign pop      = rd_en & ~empty;
  // Dropped only when full and no pop is freeing a slot in the same cycle.
  assign drop     = push_req & full & ~pop;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      prev_q     <= '0;
      div_cnt_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      sync_q[0] <= gpio_pins;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      prev_q <= sync_out;
      if (!sample_en || mode != MODE_PERIODIC || tick) div_cnt_q <= '0;
      else                                              div_cnt_q <= div_cnt_q + DIV_W'(1);
      if (drop)         overflow_q <= 1'b1;
      else if (ovf_clr) overflow_q <= 1'b0;
    end
  end

`ifdef GPIO_SAMPLER_TSTAMP_EN
  logic [TSTAMP_W-1:0] tstamp_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) tstamp_q <= '0;
    else       tstamp_q <= tstamp_q + TSTAMP_W'(1);
  end

  assign wdata       = {tstamp_q, sync_out};
  assign dout_tstamp = rdata[DataW-1:WIDTH];
`else
  assign wdata = sync_out;
`endif

  gpio_sync_fifo #(
    .DATA_W (DataW),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (push_req),
    .pop   (rd_en),
    .wdata (wdata),
    .rdata (rdata),
    .level (level),
    .full  (full),
    .empty (empty)
  );

  assign dout       = rdata[WIDTH-1:0];
  assign dout_valid = ~empty;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_gpio_in_sampler.sv
// Scoreboard bench for gpio_in_sampler: expected samples are queued as pushes are predicted
// and compared as the FIFO head is drained.
module tb_gpio_in_sampler;

  localparam int WIDTH = 32;
  localparam int DEPTH = 4;

  logic             clk = 1'b0;
  logic             rstn = 1'b0;
  logic [WIDTH-1:0] gpio_pins = '0;
  logic             sample_en = 1'b0;
  logic             mode = 1'b0;
  logic [15:0]      div = '0;
  logic             rd_en = 1'b0;
  logic             ovf_clr = 1'b0;
  logic [WIDTH-1:0] dout;
  logic             dout_valid;
  logic [2:0]       level;
  logic             full;
  logic             overflow;
`ifdef GPIO_SAMPLER_TSTAMP_EN
  logic [15:0]      dout_tstamp;
`endif

  int vectors = 0;
  int miscompares = 0;
  logic [WIDTH-1:0] exp_q [$];
  // Two-stage synchroniser reference: s1 is the value a push would capture this cycle.
  logic [WIDTH-1:0] s0 = '0, s1 = '0;

  gpio_in_sampler #(
    .WIDTH       (WIDTH),
    .DEPTH       (DEPTH),
    .SYNC_STAGES (2)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .gpio_pins   (gpio_pins),
    .sample_en   (sample_en),
    .mode        (mode),
    .div         (div),
    .rd_en       (rd_en),
    .dout        (dout),
    .dout_valid  (dout_valid),
`ifdef GPIO_SAMPLER_TSTAMP_EN
    .dout_tstamp (dout_tstamp),
`endif
    .level       (level),
    .full        (full),
    .overflow    (overflow),
    .ovf_clr     (ovf_clr)
  );

  always #5 clk = ~clk;

  task automatic tick();
    s1 = s0;
    s0 = gpio_pins;
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < DEPTH + 2 && exp_q.size() > 0; i++) begin
      vectors++;
      if ({dout_valid, dout} !== {1'b1, exp_q[0]}) begin
        miscompares++;
        $display("FAIL %s_head: got valid=%0b dout=%h, want valid=1 dout=%h",
                 name, dout_valid, dout, exp_q[0]);
      end
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
      void'(exp_q.pop_front());
    end
    vectors++;
    if ({exp_q.size() == 0, level, dout_valid} !== {1'b1, 3'd0, 1'b0}) begin
      miscompares++;
      $display("FAIL %s_empty: got level=%0d valid=%0b left=%0d, want level=0 valid=0 left=0",
               name, level, dout_valid, exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    #12;
    rstn = 1'b1;
    s0 = '0;
    s1 = '0;
    for (int i = 0; i < 10; i++) begin
      tick();
      vectors++;
      if ({dout, dout_valid, level, overflow, full} !== '0) begin
        miscompares++;
        $display("FAIL reset_idle[%0d]: got dout=%h valid=%0b level=%0d ovf=%0b full=%0b, want 0",
                 i, dout, dout_valid, level, overflow, full);
      end
    end
  endtask

  task automatic test_change();
    gpio_pins = 32'h0000_00A5;
    sample_en = 1'b1;
    mode      = 1'b0;
    for (int e = 1; e <= 3; e++) begin
      tick();
      vectors++;
      if (dout_valid !== (e == 3)) begin
        miscompares++;
        $display("FAIL change_latency[edge %0d]: got valid=%0b, want %0b", e, dout_valid, e == 3);
      end
    end
    exp_q.push_back(32'h0000_00A5);
    for (int i = 0; i < 5; i++) begin
      tick();
      vectors++;
      if (level !== 3'd1) begin
        miscompares++;
        $display("FAIL change_stable[%0d]: got level=%0d, want 1", i, level);
      end
    end
    sample_en = 1'b0;
    drain("change");
  endtask

  task automatic test_periodic();
    logic [2:0] exp_lvl;
    gpio_pins = 32'h1234_5678;
    repeat (3) tick();
    sample_en = 1'b1;
    mode      = 1'b1;
    div       = 16'd3;
    for (int n = 1; n <= 20; n++) begin
      tick();
      if (n % 4 == 0 && n <= 16) exp_q.push_back(s1);
      exp_lvl = (n / 4 > 4) ? 3'd4 : 3'(n / 4);
      vectors++;
      if ({level, full, overflow} !== {exp_lvl, exp_lvl == 3'd4, n >= 20}) begin
        miscompares++;
        $display("FAIL periodic[edge %0d]: got level=%0d full=%0b ovf=%0b, want %0d %0b %0b",
                 n, level, full, overflow, exp_lvl, exp_lvl == 3'd4, n >= 20);
      end
      if (n >= 4) begin
        vectors++;
        if (dout !== exp_q[0]) begin
          miscompares++;
          $display("FAIL periodic_head[edge %0d]: got %h, want %h", n, dout, exp_q[0]);
        end
      end
    end
    sample_en = 1'b0;
    ovf_clr   = 1'b1;
    tick();
    ovf_clr = 1'b0;
    vectors++;
    if ({overflow, level} !== {1'b0, 3'd4}) begin
      miscompares++;
      $display("FAIL ovf_clr: got ovf=%0b level=%0d, want ovf=0 level=4", overflow, level);
    end
  endtask

  task automatic test_back_to_back();
    div       = 16'd0;
    mode      = 1'b1;
    sample_en = 1'b1;
    rd_en     = 1'b1;
    for (int n = 0; n < 12; n++) begin
      gpio_pins = 32'hC0DE_0000 + n;
      vectors++;
      if (dout !== exp_q[0]) begin
        miscompares++;
        $display("FAIL b2b_head[%0d]: got %h, want %h", n, dout, exp_q[0]);
      end
      void'(exp_q.pop_front());
      exp_q.push_back(s1);
      tick();
      vectors++;
      if ({level, overflow} !== {3'd4, 1'b0}) begin
        miscompares++;
        $display("FAIL b2b_level[%0d]: got level=%0d ovf=%0b, want 4 0", n, level, overflow);
      end
    end
    rd_en     = 1'b0;
    sample_en = 1'b0;
    tick();
    drain("b2b");
  endtask

  task automatic test_empty_rd();
    logic [WIDTH-1:0] val;
    rd_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if ({level, dout_valid, overflow, full} !== '0) begin
        miscompares++;
        $display("FAIL empty_rd[%0d]: got level=%0d valid=%0b ovf=%0b full=%0b, want 0",
                 i, level, dout_valid, overflow, full);
      end
    end
    mode      = 1'b1;
    div       = 16'd0;
    sample_en = 1'b1;
    val       = s1;
    tick();
    sample_en = 1'b0;
    rd_en     = 1'b0;
    vectors++;
    if ({level, dout} !== {3'd1, val}) begin
      miscompares++;
      $display("FAIL push_pop_empty: got level=%0d dout=%h, want 1 %h", level, dout, val);
    end
    exp_q.push_back(val);
    drain("push_pop_empty");
  endtask

  task automatic test_reset_mid();
    gpio_pins = 32'h5A5A_F00D;
    mode      = 1'b1;
    div       = 16'd0;
    sample_en = 1'b1;
    tick();
    tick();
    sample_en = 1'b0;
    vectors++;
    if (level !== 3'd2) begin
      miscompares++;
      $display("FAIL reset_mid_fill: got level=%0d, want 2", level);
    end
    #3;
    rstn = 1'b0;
    #1;
    vectors++;
    if ({dout, dout_valid, level, full, overflow} !== '0) begin
      miscompares++;
      $display("FAIL reset_async: got dout=%h valid=%0b level=%0d, want 0",
               dout, dout_valid, level);
    end
    #3;
    rstn = 1'b1;
    s0 = '0;
    s1 = '0;
    exp_q.delete();
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if ({dout_valid, level, dout} !== '0) begin
        miscompares++;
        $display("FAIL reset_flushed[%0d]: got valid=%0b level=%0d dout=%h, want 0",
                 i, dout_valid, level, dout);
      end
    end
  endtask

  initial begin
    test_reset();
    test_change();
    test_periodic();
    test_back_to_back();
    test_empty_rd();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
